// File: rtl/bank_mem_pkg.sv
// bank_mem_pkg -- shared types and defaults for the bank_mem block.
//   state_t   : S_CLEAR (sweeping the array to zero) / S_RUN (serving requests)
//   DW_DEF    : default data width in bits
//   DEPTH_DEF : default number of words
package bank_mem_pkg;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 16;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/bank_mem_if.sv
// bank_mem_if -- request/response bus of bank_mem.
//   master : drives sel, wr, addr, wdata, be, clr; receives ready, rdata, rvalid, parity_err
//   slave  : the memory side of the same signals
import bank_mem_pkg::*;

interface bank_mem_if #(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic            sel;
  logic            wr;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic            clr;
  logic            ready;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            parity_err;

  modport master (output sel, wr, addr, wdata, be, clr,
                  input  ready, rdata, rvalid, parity_err);
  modport slave  (input  sel, wr, addr, wdata, be, clr,
                  output ready, rdata, rvalid, parity_err);
endinterface

// File: rtl/bank_mem_clr.sv
// bank_mem_clr -- clear-sweep sequencer for bank_mem.
//   clk, reset   : clock, asynchronous active-high reset
//   i_clr        : clear request (only honoured while serving requests)
//   o_ready      : 1 while serving requests, 0 while sweeping
//   o_clr_addr   : word being zeroed this cycle
//   o_clr_we     : zero-write enable for o_clr_addr
// A sweep visits words 0..DEPTH-1, one per cycle, so it lasts exactly DEPTH cycles.
import bank_mem_pkg::*;

module bank_mem_clr #(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  output logic          o_ready,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_clr_we
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (i_clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    o_ready    = (r_state == S_RUN);
    o_clr_we   = (r_state == S_CLEAR);
    o_clr_addr = r_cnt;
  end
endmodule

// File: rtl/bank_mem.sv
// bank_mem -- byte-writable single-port word memory with self-clearing sweep.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : bank_mem_if slave (sel/wr/addr/wdata/be/clr in; ready/rdata/rvalid/parity_err out)
// Reads have 1-cycle latency; rdata holds between reads. Out-of-range addresses
// drop writes and read back zero.
// Optional feature: define BANK_MEM_PARITY_EN to keep an even-parity bit per byte
// and flag mismatches on reads; otherwise parity_err is tied low.
import bank_mem_pkg::*;

module bank_mem #(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DW / 8
) (
  input  logic       clk,
  input  logic       reset,
  bank_mem_if.slave  bus
);
  logic          w_ready, w_clr_we, w_acc, w_wr, w_rd, w_in_rng;
  logic [AW-1:0] w_clr_addr;
  logic [NB-1:0] w_we_byte;
  logic [DW-1:0] w_mem_rd;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  bank_mem_clr #(.DEPTH(DEPTH)) u_clr (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (bus.clr),
    .o_ready    (w_ready),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we)
  );

  // clr wins over a request presented in the same cycle
  assign w_acc    = w_ready & bus.sel & ~bus.clr;
  assign w_in_rng = 32'(bus.addr) < DEPTH;
  assign w_wr     = w_acc & bus.wr & w_in_rng;
  assign w_rd     = w_acc & ~bus.wr;
  assign w_mem_rd = w_in_rng ? r_mem[bus.addr] : '0;

`ifdef BANK_MEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par_rd, w_par_bad;
  logic          r_perr;
  assign w_par_rd = w_in_rng ? r_par[bus.addr] : '0;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign w_we_byte[b] = w_wr & bus.be[b];
`ifdef BANK_MEM_PARITY_EN
    assign w_par_bad[b] = w_par_rd[b] != (^w_mem_rd[8*b +: 8]);
`endif
  end

  // Array has no reset: the sweep that follows every reset zeroes it.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
`ifdef BANK_MEM_PARITY_EN
      r_par[w_clr_addr] <= '0;
`endif
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_we_byte[b]) begin
          r_mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
`ifdef BANK_MEM_PARITY_EN
          r_par[bus.addr][b] <= ^bus.wdata[8*b +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_mem_rd;
    end
  end

`ifdef BANK_MEM_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_perr <= 1'b0;
    else       r_perr <= w_rd & (|w_par_bad);
  end
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.ready  = w_ready;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
endmodule

// File: doc/bank_mem.md
BANK_MEM -- requirements
Module: bank_mem

Interface
REQ-001 SHALL have parameter DW, 16, data word width in bits; a multiple of 8, at least 8.
REQ-002 SHALL have parameter DEPTH, 16, number of words; at least 2, power of two not required.
REQ-003 SHALL have derived localparam AW = $clog2(DEPTH), the address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sel  input  1  request strobe.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read; sampled only when sel=1.
REQ-008 SHALL have port addr  input  AW  word address.
REQ-009 SHALL have port wdata  input  DW  write data.
REQ-010 SHALL have port be  input  DW/8  byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port clr  input  1  one-cycle request to zero the whole array.
REQ-012 SHALL have port ready  output  1  1 = requests accepted; 0 = clear sweep in progress.
REQ-013 SHALL have port rdata  output  DW  read data, registered.
REQ-014 SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-015 SHALL have port parity_err  output  1  read parity mismatch flag, qualified by rvalid.

Function
REQ-016 SHALL have two states: S_CLEAR, which sweeps the array, and S_RUN, which serves requests.
REQ-017 In S_CLEAR, SHALL write 0 to mem[cnt] each cycle and increment cnt from 0; at cnt=DEPTH-1, SHALL move to S_RUN and clear cnt; a sweep therefore takes exactly DEPTH cycles.
REQ-018 ready SHALL be 1 only in S_RUN.
REQ-019 While ready=0, sel, wr and clr SHALL be ignored, with no queueing.
REQ-020 In S_RUN, clr=1 SHALL move to S_CLEAR on the next edge and override any sel in the same cycle; that request is dropped.
REQ-021 A write (sel=1, wr=1, ready=1) SHALL update only the bytes whose be bit is 1, at that edge; be=0 is a legal no-op.
REQ-022 A read (sel=1, wr=0, ready=1) SHALL register mem[addr] into rdata and pulse rvalid for exactly one cycle at the following edge (1-cycle latency).
REQ-023 Back-to-back reads SHALL be accepted every cycle.
REQ-024 A read immediately after a write to the same address SHALL return the written data.
REQ-025 rdata SHALL hold its last value when rvalid=0.
REQ-026 For addr >= DEPTH: writes SHALL be discarded; reads SHALL return rdata=0 with rvalid=1 and parity_err=0.

Reset
REQ-027 reset assertion SHALL immediately force: state=S_CLEAR, cnt=0, ready=0, rvalid=0, rdata=0, parity_err=0.
REQ-028 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0.
REQ-029 The sweep SHALL begin on the first clk edge after reset deasserts.

Configuration
REQ-030 With macro BANK_MEM_PARITY_EN defined, SHALL store one even-parity bit per byte, written with each enabled byte and 0 during the sweep.
REQ-031 With BANK_MEM_PARITY_EN defined, on every valid read SHALL drive parity_err=1 with rvalid if any byte's stored parity mismatches its data, else 0.
REQ-032 Without BANK_MEM_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be constant 0.

Structure
REQ-033 Package bank_mem_pkg SHALL hold the state enum (S_CLEAR, S_RUN) and default constants DW_DEF=16 and DEPTH_DEF=16.
REQ-034 One sub-module, bank_mem_clr, SHALL contain the sweep counter and state register and output ready, the clear address and the clear write enable.
REQ-035 The array and read path SHALL remain in bank_mem.

Verification
REQ-036 Default parameters, reset for 2 cycles then release: ready=0 for exactly 16 cycles then 1; a read of every address returns 0000.
REQ-037 Write A5A5 to addr 1 with be=11, then write 5A5A to addr 2 with be=01, then read 1 and 2: rdata=A5A5, then 005A, each with a 1-cycle rvalid pulse.
REQ-038 After REQ-037, pulse clr together with a write of FFFF to addr 3: ready drops for 16 cycles; a read of addr 3 then returns 0000 and addr 1 returns 0000.
REQ-039 DEPTH=12, DW=32: write DEADBEEF to addr 13 and read addr 13 -> rdata=00000000 and rvalid=1; reads of addr 0..11 unaffected.
REQ-040 BANK_MEM_PARITY_EN defined: write 1234 to addr 5, force-flip its stored parity bit, read addr 5 -> rdata=1234 and parity_err=1 with rvalid; reread after rewriting addr 5 -> parity_err=0.
REQ-041 Assert reset at sweep cycle 7: ready stays 0, and the sweep restarts and lasts a full 16 cycles after release.
